// File: rtl/digit_scan_seq.sv
// Multiplexed display digit scanner: walks sel through 0..NDIG-1, DWELL cycles per digit.
// Optional macro SCAN_BLANK_EN adds BLANK dead-time cycles between digits (sel_valid low).
module digit_scan_seq #(
  parameter int DWELL = 1000,
  parameter int NDIG  = 4,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       frame_done,
  output logic       busy
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [7:0] BLANK_M1 = 8'(BLANK - 1);
  logic [7:0] bcnt;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1
  } state_t;

  logic unused_blank_cfg;
  assign unused_blank_cfg = ^8'(BLANK);
`endif

  localparam logic [15:0] DWELL_M1 = 16'(DWELL - 1);
  localparam logic [1:0]  LAST_DIG = 2'(NDIG - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        last_dig;
  logic [1:0]  next_sel;

  assign last_dig = (sel == LAST_DIG);
  assign next_sel = last_dig ? 2'd0 : (sel + 2'd1);

  // Scan sequencer: state, dwell/blank counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 16'd0;
      sel        <= 2'd0;
      sel_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
`ifdef SCAN_BLANK_EN
      bcnt       <= 8'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state     <= ST_SHOW;
            cnt       <= 16'd0;
            sel       <= 2'd0;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == DWELL_M1) begin
            cnt <= 16'd0;
            // en only matters at the frame boundary; mid-frame it is ignored
            if (last_dig && !en) begin
              frame_done <= 1'b1;
              state      <= ST_IDLE;
              sel        <= 2'd0;
              sel_valid  <= 1'b0;
              busy       <= 1'b0;
            end else begin
              frame_done <= last_dig;
`ifdef SCAN_BLANK_EN
              state      <= ST_BLANK;
              sel_valid  <= 1'b0;
              bcnt       <= 8'd0;
`else
              sel        <= next_sel;
`endif
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          if (bcnt == BLANK_M1) begin
            bcnt      <= 8'd0;
            state     <= ST_SHOW;
            sel       <= next_sel;
            sel_valid <= 1'b1;
          end else begin
            bcnt <= bcnt + 8'd1;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          cnt       <= 16'd0;
          sel       <= 2'd0;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
